branch_hazard_unit: RTL and testbench

Stall and flush controller for the ID-stage branch resolution path of the 5-stage MIPS pipeline. It detects the dependencies the ID-stage comparator forwarding cannot cover and the classic load-use hazard. For each one it holds PC and IF/ID for exactly the required number of cycles and inserts bubbles into ID/EX. It also squashes the wrong-path fetch on a taken branch or jump, and keeps saturating stall/flush performance counters.

---
 rtl/branch_hazard_unit.sv | 147 ++++++++++++++
 tb/tb_branch_hazard_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_unit.sv
// branch_hazard_unit
//   Stall/flush controller for the ID-stage branch resolution path of a
//   5-stage MIPS pipeline. It detects load-use hazards and branch operand
//   dependencies that ID-stage forwarding cannot cover. For each hazard it
//   holds PC and IF/ID for the required number of cycles and bubbles ID/EX.
//   It squashes the wrong-path fetch on a taken branch or jump, and keeps
//   saturating stall/flush performance counters.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   IF_ID_rs, IF_ID_rt            source registers of the ID instruction
//   IF_ID_isbranch, IF_ID_usesrt  ID instruction is beq/bne; reads rt
//   ID_EX_regres/MEMRead/RegWrite producer in EX
//   EX_MEM_regres/MEMRead/RegWrite producer in MEM
//   branch_taken, jump            ID redirect information
//   ext_stall                     memory wait, freezes the front end
//   PCWrite, IF_IDWrite           load enables
//   ID_EX_bubble, IF_ID_flush     bubble insert / wrong-path squash
//   stall_cycles, flush_count     saturating performance counters
module branch_hazard_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_isbranch,
    input  logic             IF_ID_usesrt,
    input  logic [4:0]       ID_EX_regres,
    input  logic             ID_EX_MEMRead,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       EX_MEM_regres,
    input  logic             EX_MEM_MEMRead,
    input  logic             EX_MEM_RegWrite,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             ext_stall,
    output logic             PCWrite,
    output logic             IF_IDWrite,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t state, state_nxt;
    logic   rem, rem_nxt;

    logic ex_match, mem_match;
    logic hz_lu, hz_ba, hz_bl1, hz_bl2;
    logic hz_any;
    logic stall_drv;

    // A producer only matters if it writes a nonzero register that the ID
    // instruction actually reads.
    assign ex_match  = ID_EX_RegWrite && (ID_EX_regres != 5'd0) &&
                       ((ID_EX_regres == IF_ID_rs) ||
                        (IF_ID_usesrt && (ID_EX_regres == IF_ID_rt)));
    assign mem_match = EX_MEM_RegWrite && (EX_MEM_regres != 5'd0) &&
                       ((EX_MEM_regres == IF_ID_rs) ||
                        (IF_ID_usesrt && (EX_MEM_regres == IF_ID_rt)));

    assign hz_lu  = !IF_ID_isbranch && ID_EX_MEMRead  && ex_match;
    assign hz_ba  =  IF_ID_isbranch && !ID_EX_MEMRead && ex_match;
    assign hz_bl1 =  IF_ID_isbranch && ID_EX_MEMRead  && ex_match;
    assign hz_bl2 =  IF_ID_isbranch && EX_MEM_MEMRead && mem_match;
    assign hz_any = hz_lu || hz_ba || hz_bl1 || hz_bl2;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            rem   <= 1'b0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // Next-state logic; ext_stall freezes the FSM.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        if (!ext_stall) begin
            unique case (state)
                RUN: begin
                    // Only a branch behind a load needs a second stall cycle.
                    if (hz_bl1) begin
                        state_nxt = HOLD;
                        rem_nxt   = 1'b1;
                    end
                end
                HOLD: begin
                    rem_nxt = rem - 1'b1;
                    if (rem_nxt == 1'b0) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    rem_nxt   = 1'b0;
                end
            endcase
        end
    end

    // Output logic (Mealy)
    always_comb begin
        PCWrite      = 1'b1;
        IF_IDWrite   = 1'b1;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = 1'b0;
        stall_drv    = 1'b0;
        if (rst) begin
            // Normal enables, no flush, whatever the other inputs are.
        end else if (ext_stall) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
        end else if ((state == HOLD) || hz_any) begin
            // branch_taken is not trusted while operands are still in flight.
            PCWrite      = 1'b0;
            IF_IDWrite   = 1'b0;
            ID_EX_bubble = 1'b1;
            stall_drv    = 1'b1;
        end else begin
            IF_ID_flush = jump || (IF_ID_isbranch && branch_taken);
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_drv && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (IF_ID_flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_hazard_unit.sv
// tb_branch_hazard_unit
//   Directed test of branch_hazard_unit. Two instances share the stimulus:
//   one with the default 16-bit counters and one with 2-bit counters, so
//   saturation can be observed.
module tb_branch_hazard_unit;

    logic       clk;
    logic       rst;
    logic [4:0] IF_ID_rs, IF_ID_rt;
    logic       IF_ID_isbranch, IF_ID_usesrt;
    logic [4:0] ID_EX_regres;
    logic       ID_EX_MEMRead, ID_EX_RegWrite;
    logic [4:0] EX_MEM_regres;
    logic       EX_MEM_MEMRead, EX_MEM_RegWrite;
    logic       branch_taken, jump, ext_stall;

    logic        PCWrite, IF_IDWrite, ID_EX_bubble, IF_ID_flush;
    logic [15:0] stall_cycles, flush_count;
    logic        s_PCWrite, s_IF_IDWrite, s_ID_EX_bubble, s_IF_ID_flush;
    logic [1:0]  s_stall_cycles, s_flush_count;

    int unsigned n_tests;
    int unsigned n_fail;
    int unsigned exp_stall;
    int unsigned exp_flush;

    branch_hazard_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
        .IF_ID_isbranch(IF_ID_isbranch), .IF_ID_usesrt(IF_ID_usesrt),
        .ID_EX_regres(ID_EX_regres), .ID_EX_MEMRead(ID_EX_MEMRead),
        .ID_EX_RegWrite(ID_EX_RegWrite),
        .EX_MEM_regres(EX_MEM_regres), .EX_MEM_MEMRead(EX_MEM_MEMRead),
        .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .branch_taken(branch_taken), .jump(jump), .ext_stall(ext_stall),
        .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite),
        .ID_EX_bubble(ID_EX_bubble), .IF_ID_flush(IF_ID_flush),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    branch_hazard_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
        .IF_ID_isbranch(IF_ID_isbranch), .IF_ID_usesrt(IF_ID_usesrt),
        .ID_EX_regres(ID_EX_regres), .ID_EX_MEMRead(ID_EX_MEMRead),
        .ID_EX_RegWrite(ID_EX_RegWrite),
        .EX_MEM_regres(EX_MEM_regres), .EX_MEM_MEMRead(EX_MEM_MEMRead),
        .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .branch_taken(branch_taken), .jump(jump), .ext_stall(ext_stall),
        .PCWrite(s_PCWrite), .IF_IDWrite(s_IF_IDWrite),
        .ID_EX_bubble(s_ID_EX_bubble), .IF_ID_flush(s_IF_ID_flush),
        .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got,
                         input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned sat3(input int unsigned v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic idle();
        IF_ID_rs = '0; IF_ID_rt = '0;
        IF_ID_isbranch = 1'b0; IF_ID_usesrt = 1'b0;
        ID_EX_regres = '0; ID_EX_MEMRead = 1'b0; ID_EX_RegWrite = 1'b0;
        EX_MEM_regres = '0; EX_MEM_MEMRead = 1'b0; EX_MEM_RegWrite = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; ext_stall = 1'b0;
    endtask

    // One clock cycle: check the Mealy outputs mid-cycle, then the counters
    // just after the edge against the running hand tally.
    task automatic cyc(input string tag, input logic pcw, input logic ifw,
                       input logic bub, input logic fl);
        @(negedge clk);
        check({tag, ".PCWrite"},      32'(PCWrite),      32'(pcw));
        check({tag, ".IF_IDWrite"},   32'(IF_IDWrite),   32'(ifw));
        check({tag, ".ID_EX_bubble"}, 32'(ID_EX_bubble), 32'(bub));
        check({tag, ".IF_ID_flush"},  32'(IF_ID_flush),  32'(fl));
        if (rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (bub) exp_stall++;
            if (fl)  exp_flush++;
        end
        @(posedge clk);
        #1;
        check({tag, ".stall_cycles"},     32'(stall_cycles),   exp_stall);
        check({tag, ".flush_count"},      32'(flush_count),    exp_flush);
        check({tag, ".sat_stall_cycles"}, 32'(s_stall_cycles), sat3(exp_stall));
        check({tag, ".sat_flush_count"},  32'(s_flush_count),  sat3(exp_flush));
    endtask

    initial begin
        n_tests = 0; n_fail = 0; exp_stall = 0; exp_flush = 0;
        idle();
        rst = 1'b1;
        #1;
        // Reset overrides a visible load-use hazard and a jump
        ID_EX_MEMRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_regres = 5'd5;
        IF_ID_rs = 5'd5; jump = 1'b1;
        cyc("rst0", 1, 1, 0, 0);
        cyc("rst1", 1, 1, 0, 0);
        rst = 1'b0; idle();
        cyc("idle", 1, 1, 0, 0);

        // Load-use: one stall cycle, then normal once EX holds the bubble
        ID_EX_MEMRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_regres = 5'd5;
        IF_ID_rs = 5'd5;
        cyc("lu_stall", 0, 0, 1, 0);
        ID_EX_MEMRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_regres = 5'd0;
        cyc("lu_after", 1, 1, 0, 0);

        // rt match ignored when the instruction does not read rt
        idle();
        IF_ID_isbranch = 1'b1; IF_ID_rt = 5'd7; IF_ID_usesrt = 1'b0;
        ID_EX_RegWrite = 1'b1; ID_EX_regres = 5'd7;
        cyc("no_rt", 1, 1, 0, 0);

        // Branch after ALU: one stall with taken ignored, then flush
        IF_ID_usesrt = 1'b1; branch_taken = 1'b1;
        cyc("ba_stall", 0, 0, 1, 0);
        ID_EX_RegWrite = 1'b0; ID_EX_regres = 5'd0;
        cyc("ba_flush", 1, 1, 0, 1);

        // Branch after load: two stalls, HOLD ignores the BL2 pattern
        idle();
        IF_ID_isbranch = 1'b1; IF_ID_rs = 5'd3; branch_taken = 1'b1;
        ID_EX_MEMRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_regres = 5'd3;
        cyc("bl1_s1", 0, 0, 1, 0);
        ID_EX_MEMRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_regres = 5'd0;
        EX_MEM_MEMRead = 1'b1; EX_MEM_RegWrite = 1'b1; EX_MEM_regres = 5'd3;
        cyc("bl1_s2", 0, 0, 1, 0);
        EX_MEM_MEMRead = 1'b0; EX_MEM_RegWrite = 1'b0; EX_MEM_regres = 5'd0;
        cyc("bl1_flush", 1, 1, 0, 1);

        // Branch with the load in MEM: one stall
        idle();
        IF_ID_isbranch = 1'b1; IF_ID_rs = 5'd9;
        EX_MEM_MEMRead = 1'b1; EX_MEM_RegWrite = 1'b1; EX_MEM_regres = 5'd9;
        cyc("bl2_stall", 0, 0, 1, 0);
        EX_MEM_MEMRead = 1'b0; EX_MEM_RegWrite = 1'b0; EX_MEM_regres = 5'd0;
        cyc("bl2_after", 1, 1, 0, 0);

        // Register $0 never stalls
        idle();
        ID_EX_MEMRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_regres = 5'd0;
        cyc("zero_lu", 1, 1, 0, 0);
        IF_ID_isbranch = 1'b1;
        EX_MEM_MEMRead = 1'b1; EX_MEM_RegWrite = 1'b1; EX_MEM_regres = 5'd0;
        cyc("zero_br", 1, 1, 0, 0);

        // ext_stall mid-HOLD: HOLD stretched, one stall cycle left afterwards
        idle();
        IF_ID_isbranch = 1'b1; IF_ID_rs = 5'd3;
        ID_EX_MEMRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_regres = 5'd3;
        cyc("ext_s1", 0, 0, 1, 0);
        idle();
        ext_stall = 1'b1; branch_taken = 1'b1; IF_ID_isbranch = 1'b1;
        for (int i = 0; i < 3; i++) cyc("ext_frz", 0, 0, 0, 0);
        ext_stall = 1'b0;
        cyc("ext_s2", 0, 0, 1, 0);
        cyc("ext_flush", 1, 1, 0, 1);

        // Reset mid-HOLD: back to RUN, no residual stall
        idle();
        IF_ID_isbranch = 1'b1; IF_ID_rs = 5'd3;
        ID_EX_MEMRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_regres = 5'd3;
        cyc("rh_s1", 0, 0, 1, 0);
        idle();
        rst = 1'b1;
        cyc("rh_rst", 1, 1, 0, 0);
        rst = 1'b0;
        cyc("rh_run", 1, 1, 0, 0);

        // Jumps: flush every cycle, small counter saturates at 3
        jump = 1'b1;
        for (int i = 0; i < 5; i++) cyc("jump", 1, 1, 0, 1);
        idle();
        cyc("final", 1, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
